// File: rtl/breath_led_multi_if.sv
// Signal bundle between the key conditioning logic and the breathing-LED controller.
// master drives keys/hold and observes the LED side; slave is the controller.
interface breath_led_multi_if #(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 4,
    parameter int LW       = 4
);
    logic                key_up;
    logic                key_down;
    logic                hold;
    logic [CHANNELS-1:0] led;
    logic [LW-1:0]       level;
    logic [PWM_BITS-1:0] duty_mon;

    modport master (
        output key_up, key_down, hold,
        input  led, level, duty_mon
    );

    modport slave (
        input  key_up, key_down, hold,
        output led, level, duty_mon
    );
endinterface

// File: rtl/breath_led_multi.sv
// Multi-channel breathing LED: per-channel triangle duty ramp driving PWM, shared key-adjusted speed.
// Latency: led one clock after pwm_cnt/duty; level one clock after the key edge cycle.
// Backpressure: none; hold freezes the duty ramps while PWM and key handling keep running.
module breath_led_multi #(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 4,
    parameter int SPD_MAX  = 15,
    parameter int SPD_INIT = 8,
    parameter int LW       = $clog2(SPD_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    breath_led_multi_if.slave  bus
);
    localparam logic [PWM_BITS-1:0] PMAX     = '1;
    localparam logic [LW-1:0]       LVL_MAX  = LW'(SPD_MAX);
    localparam logic [LW-1:0]       LVL_INIT = LW'(SPD_INIT);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [LW-1:0]       pre_cnt;
    logic [LW-1:0]       level_q;
    logic                key_up_q;
    logic                key_down_q;
    logic                pe;
    logic                up_edge;
    logic                dn_edge;
    logic                step;
    logic [LW-1:0]       thr;
    logic [PWM_BITS-1:0] duty_w [CHANNELS];

    assign pe      = (pwm_cnt == PMAX);
    assign up_edge = bus.key_up & ~key_up_q;
    assign dn_edge = bus.key_down & ~key_down_q;
    assign thr     = LVL_MAX - level_q;
    // >= rather than == so a speed-up that lowers thr below pre_cnt steps at the next period end
    assign step    = pe & ~bus.hold & (pre_cnt >= thr);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt    <= '0;
            pre_cnt    <= '0;
            level_q    <= LVL_INIT;
            key_up_q   <= 1'b0;
            key_down_q <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            key_up_q   <= bus.key_up;
            key_down_q <= bus.key_down;
            if (up_edge && !dn_edge && level_q != LVL_MAX) begin
                level_q <= level_q + 1'b1;
            end else if (dn_edge && !up_edge && level_q != '0) begin
                level_q <= level_q - 1'b1;
            end
            if (pe && !bus.hold) begin
                pre_cnt <= step ? '0 : pre_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [PWM_BITS-1:0] DUTY_INIT = PWM_BITS'((i * (2 ** PWM_BITS)) / CHANNELS);

        logic [PWM_BITS-1:0] duty_r;
        logic                dir_dn_r;
        logic                led_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_r   <= DUTY_INIT;
                dir_dn_r <= 1'b0;
                led_r    <= 1'b0;
            end else begin
                led_r <= (pwm_cnt < duty_r);
                if (step) begin
                    // turn-around skips the endpoint so no duty value is shown twice in a row
                    if (!dir_dn_r) begin
                        if (duty_r == PMAX) begin
                            dir_dn_r <= 1'b1;
                            duty_r   <= PMAX - 1'b1;
                        end else begin
                            duty_r <= duty_r + 1'b1;
                        end
                    end else begin
                        if (duty_r == '0) begin
                            dir_dn_r <= 1'b0;
                            duty_r   <= {{(PWM_BITS-1){1'b0}}, 1'b1};
                        end else begin
                            duty_r <= duty_r - 1'b1;
                        end
                    end
                end
            end
        end

        assign bus.led[i] = led_r;
        assign duty_w[i]  = duty_r;
    end

    assign bus.level    = level_q;
    assign bus.duty_mon = duty_w[0];
endmodule

// File: tb/tb_breath_led_multi.sv
// Bench for breath_led_multi: per-clock scoreboard against a phase-based model plus directed checks.
module tb_breath_led_multi;
    localparam int CH    = 4;
    localparam int PB    = 4;
    localparam int SMAX  = 15;
    localparam int SINIT = 8;
    localparam int LW    = $clog2(SMAX + 1);
    localparam int PMAX  = (1 << PB) - 1;
    localparam int NPH   = 2 * PMAX;

    typedef struct packed {
        logic [CH-1:0] led;
        logic [LW-1:0] level;
        logic [PB-1:0] duty;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    breath_led_multi_if #(.CHANNELS(CH), .PWM_BITS(PB), .LW(LW)) bus ();

    breath_led_multi #(
        .CHANNELS(CH), .PWM_BITS(PB), .SPD_MAX(SMAX), .SPD_INIT(SINIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // model: each channel is a position on a 2*PMAX-step triangle; duty derived from position
    int            m_pwm;
    int            m_pre;
    int            m_level;
    bit            m_kuq;
    bit            m_kdq;
    int            m_phase [CH];
    logic [CH-1:0] m_led;
    exp_t          sb_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tri_duty(input int p);
        return (p <= PMAX) ? p : NPH - p;
    endfunction

    task automatic model_step();
        bit up;
        bit dn;
        if (rst) begin
            m_pwm   = 0;
            m_pre   = 0;
            m_level = SINIT;
            m_kuq   = 1'b0;
            m_kdq   = 1'b0;
            m_led   = '0;
            for (int i = 0; i < CH; i++) m_phase[i] = (i * (PMAX + 1) / CH) % (PMAX + 1);
        end else begin
            for (int i = 0; i < CH; i++) m_led[i] = (m_pwm < tri_duty(m_phase[i]));
            up = bus.key_up && !m_kuq;
            dn = bus.key_down && !m_kdq;
            if (m_pwm == PMAX && !bus.hold) begin
                if (m_pre + m_level >= SMAX) begin
                    m_pre = 0;
                    for (int i = 0; i < CH; i++) m_phase[i] = (m_phase[i] + 1) % NPH;
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            if (up && !dn && m_level < SMAX) m_level = m_level + 1;
            else if (dn && !up && m_level > 0) m_level = m_level - 1;
            m_pwm = (m_pwm + 1) % (PMAX + 1);
            m_kuq = bus.key_up;
            m_kdq = bus.key_down;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        e.led   = m_led;
        e.level = LW'(m_level);
        e.duty  = PB'(tri_duty(m_phase[0]));
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("sb", 32'({bus.led, bus.level, bus.duty_mon}), 32'(e));
    endtask

    task automatic wait_change(input int max, output int n);
        logic [PB-1:0] prev;
        prev = bus.duty_mon;
        n = 0;
        while (bus.duty_mon == prev && n < max) begin
            tick();
            n++;
        end
        chk("step_seen", 32'(bus.duty_mon != prev), 32'd1);
    endtask

    task automatic pulse(input bit up);
        if (up) bus.key_up = 1'b1; else bus.key_down = 1'b1;
        tick();
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        tick();
    endtask

    task automatic count_led(input int ch, output int cnt);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            cnt += int'(bus.led[ch]);
        end
    endtask

    initial begin
        int n;
        int c0;
        int c1;
        int held;
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        bus.hold     = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state and idle PWM pattern
        chk("rst_level", 32'(bus.level), 32'd8);
        chk("rst_duty", 32'(bus.duty_mon), 32'd0);
        chk("rst_led", 32'(bus.led), 32'd0);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            c0 += int'(bus.led[0]);
            c1 += int'(bus.led[1]);
        end
        chk("idle_led0_hi", 32'(c0), 32'd0);
        chk("idle_led1_hi", 32'(c1), 32'd4);

        // default-speed ramp up and turn
        wait_change(300, n);
        chk("first_step_clk", 32'(16 + n), 32'd128);
        chk("first_step_val", 32'(bus.duty_mon), 32'd1);
        for (int k = 0; k < 15; k++) begin
            wait_change(300, n);
            chk("step_clk", 32'(n), 32'd128);
            chk("step_val", 32'(bus.duty_mon), (k < 14) ? 32'(k + 2) : 32'd14);
        end

        // level saturation at max, then at zero
        for (int k = 0; k < 8; k++) pulse(1'b1);
        chk("lvl_up8", 32'(bus.level), 32'd15);
        pulse(1'b1);
        chk("lvl_sat_hi", 32'(bus.level), 32'd15);
        wait_change(600, n);
        wait_change(600, n);
        chk("fast_interval", 32'(n), 32'd16);
        for (int k = 0; k < 16; k++) pulse(1'b0);
        chk("lvl_sat_lo", 32'(bus.level), 32'd0);
        wait_change(600, n);
        wait_change(600, n);
        chk("slow_interval", 32'(n), 32'd256);

        // held key gives one step; coincident edges cancel
        bus.key_up = 1'b1;
        repeat (50) tick();
        bus.key_up = 1'b0;
        tick();
        chk("held_key", 32'(bus.level), 32'd1);
        bus.key_up   = 1'b1;
        bus.key_down = 1'b1;
        tick();
        tick();
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        tick();
        chk("both_edges", 32'(bus.level), 32'd1);

        // hold freezes duties; keys still work
        held     = tri_duty(m_phase[0]);
        bus.hold = 1'b1;
        repeat (100) tick();
        count_led(0, c0);
        chk("hold_led_a", 32'(c0), 32'(held));
        pulse(1'b1);
        chk("hold_key", 32'(bus.level), 32'd2);
        repeat (850) tick();
        count_led(0, c1);
        chk("hold_led_b", 32'(c1), 32'(held));
        chk("hold_duty", 32'(bus.duty_mon), 32'(held));
        bus.hold = 1'b0;
        wait_change(700, n);

        // mid-ramp reset at level 3, duty 9 descending
        pulse(1'b1);
        chk("lvl3", 32'(bus.level), 32'd3);
        n = 0;
        while (m_phase[0] != NPH - 9 && n < 8000) begin
            tick();
            n++;
        end
        chk("ramp_reach", 32'(m_phase[0] == NPH - 9), 32'd1);
        chk("pre_rst_duty", 32'(bus.duty_mon), 32'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_level", 32'(bus.level), 32'd8);
        chk("mid_rst_duty", 32'(bus.duty_mon), 32'd0);
        chk("mid_rst_led", 32'(bus.led), 32'd0);
        wait_change(300, n);
        chk("restart_clk", 32'(n), 32'd128);
        chk("restart_val", 32'(bus.duty_mon), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/breath_led_multi.md
Name: breath_led_multi

Overview:
- Multi-channel breathing-LED controller, parametrised in channel count, PWM resolution and speed range.
- Each channel drives a PWM LED whose duty ramps in a triangle 0→max→0. Channels start phase-staggered.
- Debounced-upstream key_up/key_down pulses adjust a shared breathing-speed level. A hold input freezes breathing.
- Sits between the board key conditioning logic and the LED pins.

Parameters:
CHANNELS, 4, number of LED channels (≥1)
PWM_BITS, 4, duty/PWM counter width; PWM period = 2^PWM_BITS clocks
SPD_MAX, 15, highest speed level (≥1)
SPD_INIT, 8, speed level after reset (≤SPD_MAX)
LW, $clog2(SPD_MAX+1), derived width of level/prescaler

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
key_up  input  1  speed-up request, level signal, already synchronous to clk
key_down  input  1  speed-down request, level signal, already synchronous to clk
hold  input  1  1 = freeze all duties (PWM keeps running)
led  output  CHANNELS  registered PWM outputs, bit i = channel i
level  output  LW  current speed level
duty_mon  output  PWM_BITS  current duty of channel 0 (monitor)

Interface (already decided):
- One clock: clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - pwm_cnt=0, pre_cnt=0, led=0, level=SPD_INIT.
  - duty[i] = (i*2^PWM_BITS/CHANNELS) mod 2^PWM_BITS; dir[i]=up.
  - Key edge registers = 0.
- Reset mid-operation: same values on the next edge, regardless of key, hold or PWM state.
- PWM counter:
  - pwm_cnt increments every clock and wraps 2^PWM_BITS-1 → 0.
  - Period end (PE) = pwm_cnt==2^PWM_BITS-1.
  - Runs regardless of hold.
- LED output:
  - led[i] <= (pwm_cnt < duty[i]); one clock latency.
  - duty=0 gives a constant 0. duty=max gives high for 2^PWM_BITS-1 of 2^PWM_BITS clocks.
- Keys:
  - Rising edge detected as key & ~key_q (key_q is a 1-cycle delayed copy).
  - Up edge only: level+1, saturating at SPD_MAX.
  - Down edge only: level-1, saturating at 0.
  - Both edges in the same cycle: no change.
  - Holding a key high produces exactly one change.
  - level updates the clock after the edge cycle.
- Prescaler and step:
  - Evaluated only at PE with hold=0. thr = SPD_MAX-level.
  - If pre_cnt ≥ thr: step all channels, pre_cnt<=0. Otherwise pre_cnt+1.
  - The ≥ compare covers a level increase that drops thr below pre_cnt: the step occurs at the next PE.
  - Resulting step interval = (SPD_MAX-level+1) PWM periods.
- Duty step per channel (triangle):
  - dir=up, duty==max: dir<=down, duty<=max-1. Otherwise duty+1.
  - dir=down, duty==0: dir<=up, duty<=1. Otherwise duty-1.
  - Full breath cycle = 2·(2^PWM_BITS-1) steps. No duty value is repeated at a turn.
- Hold:
  - hold=1 at PE: pre_cnt and duties unchanged.
  - Keys still adjust level.
  - Releasing hold resumes from the frozen pre_cnt.
- duty_mon = duty[0], combinational from the register.
- Widths: all counters wrap or saturate exactly as above. No arithmetic overflow is permitted in level or pre_cnt.

Test Plan (default parameters):
1. Reset, then idle 16 clocks -> level=8, duty_mon=0. The 4 internal duties are 0,4,8,12. led[0] stays 0. led[1] is high for 4 of each 16 clocks.
2. No keys, hold=0 -> duty_mon steps 0→1 at the 8th PE after reset, i.e. every 128 clocks. After 15 steps it reaches 15, then 14. No value is repeated at a turn.
3. Eight key_up pulses, then a ninth -> level stops at 15 (saturated). duty_mon steps every PE (16 clocks). Sixteen key_down pulses -> level=0, step every 16 periods.
4. key_up and key_down rise in the same cycle; key_up held high 50 clocks -> level unchanged by the coincident edge. The held key gives exactly +1.
5. hold=1 for 1000 clocks -> duty_mon is constant and the led duty pattern repeats unchanged. A key pulse during hold still changes level. Steps resume after release.
6. Assert rst for 1 clock mid-ramp (level=3, duty_mon=9, dir down) -> next clock: level=8, duty_mon=0, led=0, and breathing restarts as in scenario 2.
